spi_slave_obi_plug: RTL and testbench
=====================================

# spi_slave_obi_plug

System-clock-side OBI master for the SPI slave. Consumes the address, direction and wrap length that the SPI slave controller produces, plus the write-data and read-data streams that cross from the `sclk` domain through the dual-clock FIFOs. Turns them into single-word OBI bus transactions, with address auto-increment and optional wrap-around. Sits between the CDC FIFOs and the system interconnect.

## Interface
Parameters: none. Data width is fixed at 32 bits; addresses are 32-bit byte addresses, word-aligned.

- Clock and reset (already decided): one clock, `sys_clk`; reset is asynchronous and active-low, `sys_rstn`.
- `sys_clk` in 1 — system clock; all logic on its rising edge.
- `sys_rstn` in 1 — async active-low reset.
- `rxtx_addr` in 32 — start address; already synchronised.
- `rxtx_addr_valid` in 1 — one-cycle pulse; `rxtx_addr` and `rxtx_rd_wr` are valid this cycle.
- `rxtx_rd_wr` in 1 — 1 = read (bus→SPI), 0 = write.
- `wrap_length` in 16 — burst wrap length in words; 0 = no wrap. Quasi-static.
- `cs_sync` in 1 — chip-select level (1 = deselected), synchronised to `sys_clk`.
- `rx_data` in 32 — write data from the RX FIFO.
- `rx_valid` in 1 — RX FIFO not empty.
- `rx_ready` out 1 — pops the RX FIFO.
- `tx_data` out 32 — read data to the TX FIFO.
- `tx_valid` out 1 — pushes the TX FIFO.
- `tx_ready` in 1 — TX FIFO not full.
- `obi_req`, `obi_gnt` out/in 1 — OBI request/grant.
- `obi_addr` out 32, `obi_we` out 1, `obi_be` out 4, `obi_wdata` out 32 — OBI A-channel.
- `obi_rvalid` in 1, `obi_rdata` in 32 — OBI R-channel.

## Operation
- FSM states: `IDLE`, `WR_REQ`, `WR_RESP`, `RD_REQ`, `RD_RESP`. At most one OBI transaction is outstanding.
- Registers:
  - `base_addr`, `curr_addr` (32 bits).
  - `mode` (rd_wr).
  - `addr_ok` flag.
  - `wcnt` (16-bit word counter).
  - `pend_addr`/`pend_mode` plus `pend_flag`.
- Address capture:
  - `rxtx_addr_valid` in `IDLE`: `base_addr`=`curr_addr`=`rxtx_addr`, `mode`=`rxtx_rd_wr`, `wcnt`=0, `addr_ok`=1.
  - `rxtx_addr_valid` in any other state: store into the pend registers. They are applied on the next entry to `IDLE`, before any new request is issued. A second pulse overwrites the pending value.
- `IDLE`, with priority pending-apply > write > read:
  - Write: `addr_ok & ~mode & rx_valid` → `WR_REQ`.
  - Read: `addr_ok & mode & ~cs_sync & tx_ready` → `RD_REQ`.
  - Clear: `cs_sync & ~rx_valid` clears `addr_ok`.
- `WR_REQ`:
  - `obi_req`=1, `obi_we`=1, `obi_be`=4'hF, `obi_addr`=`curr_addr`, `obi_wdata`=`rx_data`.
  - All held stable until `obi_gnt`.
  - `rx_ready` = `obi_gnt` (combinational; one pop per grant).
  - On grant → `WR_RESP`.
- `WR_RESP`: wait for `obi_rvalid`; discard `obi_rdata`; → `IDLE`.
- `RD_REQ`: as `WR_REQ` but `obi_we`=0, `obi_wdata`=0. On grant → `RD_RESP`.
- `RD_RESP`: on `obi_rvalid`, register `tx_data`=`obi_rdata` and pulse `tx_valid` on the next cycle; → `IDLE`. `tx_ready` was checked at request time; this block is the only producer, so space is guaranteed.
- Address update on every grant (32-bit arithmetic, modulo 2^32):
  - If `wrap_length`≠0 and `wcnt`+1 == `wrap_length`: `curr_addr`=`base_addr`, `wcnt`=0.
  - Else: `curr_addr`+=4, `wcnt`+=1.
- `cs_sync` rising mid-transaction:
  - The in-flight request and response complete normally, and the read word is still pushed.
  - No further reads are issued.
  - Writes continue until the RX FIFO drains.
- Reset mid-transaction: everything returns to reset values immediately; the bus transaction is abandoned.

## Timing
- Reset values:
  - `obi_req`=0, `obi_we`=0, `obi_be`=0, `obi_addr`=0, `obi_wdata`=0.
  - `rx_ready`=0, `tx_valid`=0, `tx_data`=0.
  - State `IDLE`; all registers 0.
- All outputs are registered except `rx_ready` and `obi_wdata` (which is `rx_data` gated by state).
- `obi_req` rises 1 cycle after the `IDLE` decision; with a grant in that same cycle, `obi_req` is low the next cycle.
- `obi_rvalid` arrives no earlier than 1 cycle after `obi_gnt`. `rvalid` in the grant cycle is a protocol violation and is ignored.
- Minimum cycles per word with zero-wait bus: 3 (`IDLE`→`REQ`→`RESP`).
- Read latency: `tx_valid` 1 cycle after `obi_rvalid`.

## Structure
- Package `spi_slave_pkg` holds:
  - `obi_plug_state_e` (3-bit enum).
  - `OBI_BE_WORD` = 4'hF.
  - `ADDR_STRIDE` = 4.
- Single module, no sub-modules; the CDC FIFOs are instantiated by the parent.

## Test plan
- Write burst: addr 0x1000_0000 (write mode), 3 words in RX FIFO, zero-wait bus → 3 OBI writes at 0x1000_0000/04/08, `be`=F, 3 `rx_ready` pulses, each on its grant cycle.
- Read with backpressure: addr 0x2000, read mode, `tx_ready` low for 5 cycles → no `obi_req` during those cycles; after release, `tx_data` equals `obi_rdata` 1 cycle after `rvalid`.
- Wrap: `wrap_length`=3, read mode, start 0x100 → address sequence 0x100, 0x104, 0x108, 0x100, 0x104.
- Grant stall: `obi_gnt` low for 4 cycles in `WR_REQ` → `addr`/`wdata`/`we` stable throughout; exactly one pop.
- `cs_sync` rises during `RD_RESP` → pending word still pushed; no new `obi_req`; `addr_ok` cleared.
- Async reset asserted in `WR_RESP` → all outputs 0 immediately; the next `rxtx_addr_valid` restarts cleanly.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the system-clock side of the SPI slave.
package spi_slave_pkg;

  // Bus-plug sequencing: one OBI transaction outstanding at a time.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4
  } obi_plug_state_e;

  localparam logic [3:0]  OBI_BE_WORD = 4'hF;
  localparam logic [31:0] ADDR_STRIDE = 32'd4;

  // True when the word just granted is the last one before the burst wraps back to its base.
  function automatic logic wrap_hit(input logic [15:0] wcnt, input logic [15:0] wrap_len);
    return (wrap_len != 16'd0) && ((wcnt + 16'd1) == wrap_len);
  endfunction

endpackage

// File: rtl/spi_slave_obi_plug.sv
// OBI master that turns SPI-slave address/direction plus CDC FIFO streams into
// single-word bus transactions with auto-increment and optional wrap-around.
module spi_slave_obi_plug
  import spi_slave_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rstn,
  input  logic [31:0] rxtx_addr,
  input  logic        rxtx_addr_valid,
  input  logic        rxtx_rd_wr,
  input  logic [15:0] wrap_length,
  input  logic        cs_sync,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        obi_req,
  input  logic        obi_gnt,
  output logic [31:0] obi_addr,
  output logic        obi_we,
  output logic [3:0]  obi_be,
  output logic [31:0] obi_wdata,
  input  logic        obi_rvalid,
  input  logic [31:0] obi_rdata
);

  obi_plug_state_e state_q;

  logic [31:0] base_addr_q;
  logic [31:0] curr_addr_q;
  logic [31:0] curr_addr_d;
  logic        mode_q;
  logic        addr_ok_q;
  logic [15:0] wcnt_q;
  logic [15:0] wcnt_d;

  logic [31:0] pend_addr_q;
  logic        pend_mode_q;
  logic        pend_flag_q;

  logic        obi_req_q;
  logic        obi_we_q;
  logic [3:0]  obi_be_q;
  logic [31:0] obi_addr_q;
  logic [31:0] tx_data_q;
  logic        tx_valid_q;

  // Address/word-count values to adopt when the current request is granted.
  always_comb begin
    curr_addr_d = curr_addr_q + ADDR_STRIDE;
    wcnt_d      = wcnt_q + 16'd1;
    if (wrap_hit(wcnt_q, wrap_length)) begin
      curr_addr_d = base_addr_q;
      wcnt_d      = 16'd0;
    end
  end

  // Transaction sequencer with registered bus and TX outputs.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q     <= IDLE;
      base_addr_q <= 32'd0;
      curr_addr_q <= 32'd0;
      mode_q      <= 1'b0;
      addr_ok_q   <= 1'b0;
      wcnt_q      <= 16'd0;
      pend_addr_q <= 32'd0;
      pend_mode_q <= 1'b0;
      pend_flag_q <= 1'b0;
      obi_req_q   <= 1'b0;
      obi_we_q    <= 1'b0;
      obi_be_q    <= 4'd0;
      obi_addr_q  <= 32'd0;
      tx_data_q   <= 32'd0;
      tx_valid_q  <= 1'b0;
    end else begin
      tx_valid_q <= 1'b0;

      // A new address arriving mid-transaction is parked; a later one replaces it.
      if (rxtx_addr_valid && (state_q != IDLE)) begin
        pend_addr_q <= rxtx_addr;
        pend_mode_q <= rxtx_rd_wr;
        pend_flag_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (rxtx_addr_valid) begin
            // The freshest address supersedes anything parked earlier.
            base_addr_q <= rxtx_addr;
            curr_addr_q <= rxtx_addr;
            mode_q      <= rxtx_rd_wr;
            wcnt_q      <= 16'd0;
            addr_ok_q   <= 1'b1;
            pend_flag_q <= 1'b0;
          end else if (pend_flag_q) begin
            base_addr_q <= pend_addr_q;
            curr_addr_q <= pend_addr_q;
            mode_q      <= pend_mode_q;
            wcnt_q      <= 16'd0;
            addr_ok_q   <= 1'b1;
            pend_flag_q <= 1'b0;
          end else begin
            if (addr_ok_q && !mode_q && rx_valid) begin
              state_q    <= WR_REQ;
              obi_req_q  <= 1'b1;
              obi_we_q   <= 1'b1;
              obi_be_q   <= OBI_BE_WORD;
              obi_addr_q <= curr_addr_q;
            end else if (addr_ok_q && mode_q && !cs_sync && tx_ready) begin
              state_q    <= RD_REQ;
              obi_req_q  <= 1'b1;
              obi_we_q   <= 1'b0;
              obi_be_q   <= OBI_BE_WORD;
              obi_addr_q <= curr_addr_q;
            end
            // Deselected with nothing left to write: the address is spent.
            if (cs_sync && !rx_valid) begin
              addr_ok_q <= 1'b0;
            end
          end
        end

        WR_REQ, RD_REQ: begin
          if (obi_gnt) begin
            state_q     <= (state_q == WR_REQ) ? WR_RESP : RD_RESP;
            obi_req_q   <= 1'b0;
            obi_we_q    <= 1'b0;
            obi_be_q    <= 4'd0;
            obi_addr_q  <= 32'd0;
            curr_addr_q <= curr_addr_d;
            wcnt_q      <= wcnt_d;
          end
        end

        WR_RESP: begin
          if (obi_rvalid) begin
            state_q <= IDLE;
          end
        end

        RD_RESP: begin
          // TX space was confirmed before the request went out.
          if (obi_rvalid) begin
            tx_data_q  <= obi_rdata;
            tx_valid_q <= 1'b1;
            state_q    <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The RX FIFO head is the write data; it pops exactly on the accepting grant.
  assign rx_ready  = (state_q == WR_REQ) && obi_gnt;
  assign obi_wdata = (state_q == WR_REQ) ? rx_data : 32'd0;

  assign obi_req  = obi_req_q;
  assign obi_we   = obi_we_q;
  assign obi_be   = obi_be_q;
  assign obi_addr = obi_addr_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;

endmodule

// File: tb/tb_spi_slave_obi_plug.sv
// Self-checking bench: OBI slave, RX source and TX sink models plus an address/data scoreboard.
module tb_spi_slave_obi_plug;

  logic        sys_clk = 1'b0;
  logic        sys_rstn;
  logic [31:0] rxtx_addr;
  logic        rxtx_addr_valid;
  logic        rxtx_rd_wr;
  logic [15:0] wrap_length;
  logic        cs_sync;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        obi_req;
  logic        obi_gnt;
  logic [31:0] obi_addr;
  logic        obi_we;
  logic [3:0]  obi_be;
  logic [31:0] obi_wdata;
  logic        obi_rvalid;
  logic [31:0] obi_rdata;

  always #5 sys_clk = ~sys_clk;

  spi_slave_obi_plug dut (
    .sys_clk(sys_clk), .sys_rstn(sys_rstn),
    .rxtx_addr(rxtx_addr), .rxtx_addr_valid(rxtx_addr_valid), .rxtx_rd_wr(rxtx_rd_wr),
    .wrap_length(wrap_length), .cs_sync(cs_sync),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .obi_req(obi_req), .obi_gnt(obi_gnt), .obi_addr(obi_addr), .obi_we(obi_we),
    .obi_be(obi_be), .obi_wdata(obi_wdata), .obi_rvalid(obi_rvalid), .obi_rdata(obi_rdata)
  );

  typedef struct {
    logic [31:0] addr;
    bit          rd;
    logic [15:0] wrap;
    int          n;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs[6];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [31:0] rxq[$];
  logic [31:0] exp_tx[$];
  int          grant_cyc[$];
  int          rx_to_push = 0;
  bit          rand_rx = 0;
  bit          resp_pending = 0;
  int          resp_wait = 0;
  logic [31:0] resp_data = 32'd0;
  bit          resp_rd = 0;
  bit          read_rvalid_last = 0;
  int          stall_min = 0, stall_max = 0, stall_left = 0;
  int          rv_min = 1, rv_max = 1;
  bit          bp_rand = 0;
  bit          rv_noise = 0;
  int          bp_left = 0;
  logic [31:0] sess_addr = 32'd0;
  logic [15:0] sess_wrap = 16'd0;
  bit          sess_mode = 0;
  int          sess_k = 0;
  int          grants = 0, pops = 0, tx_pushes = 0, req_cycles = 0, cs_at_grant = 0;
  logic [31:0] last_addr = 32'd0;
  bit          hold_chk = 0;
  logic [31:0] hold_addr = 32'd0, hold_wdata = 32'd0;
  logic        hold_we = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // k-th word of a burst: linear from the start address, folded modulo the wrap length.
  function automatic logic [31:0] model_addr(input logic [31:0] a, input logic [15:0] w, input int k);
    int idx;
    idx = (w == 16'd0) ? k : (k % int'(w));
    return a + 32'(idx) * 32'd4;
  endfunction

  // One bus cycle: observe at the falling edge, drive the models, score accepted transfers.
  task automatic tick();
    bit push_due;
    @(negedge sys_clk);
    cyc++;
    rxtx_addr_valid = 1'b0;
    push_due = read_rvalid_last;
    read_rvalid_last = 0;
    if (push_due || tx_valid) begin
      chk("tx_valid_timing", 32'(tx_valid), 32'(push_due));
      if (tx_valid) begin
        tx_pushes++;
        if (exp_tx.size() != 0) chk("tx_data", tx_data, exp_tx.pop_front());
      end
    end
    if (obi_req) req_cycles++;
    if (hold_chk) begin
      chk("hold_req", 32'(obi_req), 32'd1);
      chk("hold_addr", obi_addr, hold_addr);
      chk("hold_we", 32'(obi_we), 32'(hold_we));
    end
    if (rx_to_push > 0 && (!rand_rx || $urandom_range(3, 0) != 0)) begin
      rxq.push_back($urandom);
      rx_to_push--;
    end
    rx_valid = (rxq.size() != 0);
    rx_data  = rx_valid ? rxq[0] : 32'h0;
    if (bp_left > 0) begin
      tx_ready = 1'b0;
      bp_left--;
    end else begin
      tx_ready = bp_rand ? ($urandom_range(2, 0) != 0) : 1'b1;
    end
    obi_rvalid = 1'b0;
    obi_rdata  = 32'h0;
    if (resp_pending) begin
      if (resp_wait == 0) begin
        obi_rvalid = 1'b1;
        obi_rdata = resp_rd ? resp_data : $urandom;
        resp_pending = 0;
        read_rvalid_last = resp_rd;
      end else begin
        resp_wait--;
      end
    end else if (rv_noise && obi_req && $urandom_range(1, 0) == 1) begin
      obi_rvalid = 1'b1;
      obi_rdata = $urandom;
    end
    obi_gnt = 1'b0;
    if (obi_req) begin
      if (!hold_chk) stall_left = $urandom_range(stall_max, stall_min);
      if (stall_left > 0) stall_left--;
      else obi_gnt = 1'b1;
    end
    #1;
    if (obi_gnt || rx_ready) chk("rx_ready", 32'(rx_ready), 32'(obi_gnt && !sess_mode));
    if (hold_chk) chk("hold_wdata", obi_wdata, hold_wdata);
    if (obi_gnt) begin
      chk("obi_addr", obi_addr, model_addr(sess_addr, sess_wrap, sess_k));
      chk("obi_we", 32'(obi_we), 32'(!sess_mode));
      chk("obi_be", 32'(obi_be), 32'hF);
      chk("obi_wdata", obi_wdata, (!sess_mode && rxq.size() != 0) ? rxq[0] : 32'h0);
      sess_k++;
      grants++;
      last_addr = obi_addr;
      grant_cyc.push_back(cyc);
      resp_pending = 1;
      resp_wait = $urandom_range(rv_max, rv_min) - 1;
      resp_rd = sess_mode;
      if (sess_mode) begin
        resp_data = $urandom;
        exp_tx.push_back(resp_data);
      end
      if (cs_at_grant != 0 && grants == cs_at_grant) cs_sync = 1'b1;
    end
    if (rx_ready && rxq.size() != 0) begin
      void'(rxq.pop_front());
      pops++;
    end
    hold_chk   = obi_req && !obi_gnt;
    hold_addr  = obi_addr;
    hold_we    = obi_we;
    hold_wdata = obi_wdata;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_obi_req"}, 32'(obi_req), 32'd0);
    chk({tag, "_obi_we"}, 32'(obi_we), 32'd0);
    chk({tag, "_obi_be"}, 32'(obi_be), 32'd0);
    chk({tag, "_obi_addr"}, obi_addr, 32'd0);
    chk({tag, "_obi_wdata"}, obi_wdata, 32'd0);
    chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    chk({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    chk({tag, "_tx_data"}, tx_data, 32'd0);
  endtask

  // Reads with n>0 deselect on the n-th grant; n==0 leaves chip-select to the caller.
  task automatic start_session(input logic [31:0] a, input bit rd, input logic [15:0] wrap, input int n);
    wrap_length = wrap;
    cs_sync = 1'b0;
    grants = 0;
    pops = 0;
    tx_pushes = 0;
    grant_cyc.delete();
    sess_addr = a;
    sess_wrap = wrap;
    sess_mode = rd;
    sess_k = 0;
    cs_at_grant = rd ? n : 0;
    if (!rd) begin
      if (rand_rx) rx_to_push = n;
      else for (int i = 0; i < n; i++) rxq.push_back($urandom);
    end
    rxtx_addr = a;
    rxtx_rd_wr = rd;
    rxtx_addr_valid = 1'b1;
  endtask

  task automatic finish_burst(input int n);
    int to;
    to = 0;
    while (!(grants >= n && !resp_pending && !read_rvalid_last && exp_tx.size() == 0) && to < 400) begin
      tick();
      to++;
    end
    if (to >= 400) chk("burst_timeout_grants", 32'(grants), 32'(n));
    cs_sync = 1'b1;
    repeat (3) tick();
    $display("burst addr=%h rd=%0d wrap=%0d words=%0d grants=%0d last=%h", sess_addr, sess_mode, sess_wrap, n, grants, last_addr);
  endtask

  task automatic run_burst(input logic [31:0] a, input bit rd, input logic [15:0] wrap, input int n);
    start_session(a, rd, wrap, n);
    finish_burst(n);
  endtask

  task automatic do_reset(input string tag);
    sys_rstn = 1'b0;
    #1;
    chk_zero(tag);
    rxq.delete();
    exp_tx.delete();
    resp_pending = 0;
    read_rvalid_last = 0;
    hold_chk = 0;
    stall_left = 0;
    rx_to_push = 0;
    cs_at_grant = 0;
    cs_sync = 1'b1;
    rx_valid = 1'b0;
    obi_gnt = 1'b0;
    obi_rvalid = 1'b0;
    tick();
    tick();
    sys_rstn = 1'b1;
    tick();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int to;
    int p0;
    logic [31:0] ra;
    bit rrd;
    logic [15:0] rw;
    int rn;

    vecs[0] = '{32'h1000_0000, 1'b0, 16'd0, 3, 32'h1000_0008};
    vecs[1] = '{32'h0000_0100, 1'b1, 16'd3, 5, 32'h0000_0104};
    vecs[2] = '{32'h2000_0FF0, 1'b0, 16'd2, 4, 32'h2000_0FF4};
    vecs[3] = '{32'hFFFF_FFF8, 1'b1, 16'd0, 3, 32'h0000_0000};
    vecs[4] = '{32'h0000_0040, 1'b0, 16'd1, 3, 32'h0000_0040};
    vecs[5] = '{32'h0000_8000, 1'b1, 16'd4, 6, 32'h0000_8004};

    sys_rstn = 1'b0;
    rxtx_addr = 32'd0;
    rxtx_addr_valid = 1'b0;
    rxtx_rd_wr = 1'b0;
    wrap_length = 16'd0;
    cs_sync = 1'b1;
    rx_data = 32'd0;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    obi_gnt = 1'b0;
    obi_rvalid = 1'b0;
    obi_rdata = 32'd0;

    repeat (3) tick();
    chk_zero("reset");
    sys_rstn = 1'b1;
    tick();

    // Zero-wait write burst: three words, one grant every three cycles.
    run_burst(32'h1000_0000, 1'b0, 16'd0, 3);
    chk("zw_grants", 32'(grant_cyc.size()), 32'd3);
    if (grant_cyc.size() == 3) chk("zw_spacing", 32'(grant_cyc[2] - grant_cyc[0]), 32'd6);
    chk("zw_pops", 32'(pops), 32'd3);
    chk("zw_last", last_addr, 32'h1000_0008);

    // Table of bursts under mildly random bus timing.
    stall_min = 0; stall_max = 2; rv_min = 1; rv_max = 3;
    for (int i = 0; i < 6; i++) begin
      run_burst(vecs[i].addr, vecs[i].rd, vecs[i].wrap, vecs[i].n);
      chk("vec_grants", 32'(grants), 32'(vecs[i].n));
      chk("vec_last_addr", last_addr, vecs[i].exp_last);
      chk("vec_xfers", 32'(vecs[i].rd ? tx_pushes : pops), 32'(vecs[i].n));
    end

    // TX backpressure holds off the read request.
    stall_min = 0; stall_max = 0; rv_min = 1; rv_max = 1;
    bp_left = 6;
    start_session(32'h0000_2000, 1'b1, 16'd0, 1);
    tick();
    req_cycles = 0;
    repeat (5) tick();
    chk("bp_no_req", 32'(req_cycles), 32'd0);
    finish_burst(1);
    chk("bp_grants", 32'(grants), 32'd1);
    chk("bp_pushes", 32'(tx_pushes), 32'd1);

    // Grant held off four cycles: request stable, one pop.
    stall_min = 4; stall_max = 4;
    run_burst(32'h0000_3000, 1'b0, 16'd0, 1);
    chk("stall_grants", 32'(grants), 32'd1);
    chk("stall_pops", 32'(pops), 32'd1);
    stall_min = 0; stall_max = 0;

    // Deselect while a read response is outstanding.
    rv_min = 3; rv_max = 3;
    start_session(32'h0000_6000, 1'b1, 16'd0, 0);
    to = 0;
    while (grants < 1 && to < 50) begin tick(); to++; end
    chk("cs_first_grant", 32'(grants), 32'd1);
    tick();
    cs_sync = 1'b1;
    p0 = tx_pushes;
    req_cycles = 0;
    repeat (8) tick();
    chk("cs_push", 32'(tx_pushes - p0), 32'd1);
    chk("cs_no_req", 32'(req_cycles), 32'd0);
    cs_sync = 1'b0;
    repeat (6) tick();
    chk("cs_addr_ok_cleared", 32'(req_cycles), 32'd0);
    cs_sync = 1'b1;
    tick();

    // Reset while a write request is stalled.
    rv_min = 1; rv_max = 1; stall_min = 10; stall_max = 10;
    start_session(32'h0000_7000, 1'b0, 16'd0, 2);
    req_cycles = 0;
    to = 0;
    while (req_cycles == 0 && to < 50) begin tick(); to++; end
    chk("rstreq_seen", 32'(req_cycles != 0), 32'd1);
    tick();
    do_reset("rst_in_req");

    // Reset while waiting on a write response, then a clean restart.
    stall_min = 0; stall_max = 0; rv_min = 6; rv_max = 6;
    start_session(32'h0000_7100, 1'b0, 16'd0, 2);
    to = 0;
    while (grants < 1 && to < 50) begin tick(); to++; end
    tick();
    do_reset("rst_in_resp");
    rv_min = 1; rv_max = 1;
    run_burst(32'h0000_4000, 1'b0, 16'd0, 2);
    chk("restart_grants", 32'(grants), 32'd2);
    chk("restart_last", last_addr, 32'h0000_4004);

    // Randomised bursts with bus stalls, response delay, FIFO gaps and stray rvalid.
    bp_rand = 1; rand_rx = 1; rv_noise = 1;
    stall_min = 0; stall_max = 3; rv_min = 1; rv_max = 3;
    for (int i = 0; i < 20; i++) begin
      ra  = $urandom & 32'hFFFF_FFFC;
      rrd = $urandom_range(1, 0) == 1;
      rw  = 16'($urandom_range(4, 0));
      rn  = $urandom_range(8, 1);
      run_burst(ra, rrd, rw, rn);
      chk("rnd_grants", 32'(grants), 32'(rn));
      chk("rnd_last_addr", last_addr, model_addr(ra, rw, rn - 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
